shift_reg_univ: RTL

Parametrised universal shift register: N stages of W-bit lanes, four shift modes (shift up/down, rotate up/down) and parallel load.
Adds a burst engine that performs a programmed number of single-stage shifts autonomously, with busy/done status and an ena stall.
Used as the general shift/rotate/serialise primitive in datapaths and serial interfaces. It replaces the single-bit, single-direction shifter.

---
 rtl/shift_reg_univ_if.sv | 31 +++
 rtl/shift_reg_univ.sv | 110 +++++++++++
 2 files changed

// File: rtl/shift_reg_univ_if.sv
// Control/status bundle for shift_reg_univ: the master drives the controls and the slave
// (the shift register) drives the stage and burst status outputs.
interface shift_reg_univ_if #(
    parameter int unsigned W     = 1,
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 4
) ();
    logic             ena;
    logic [1:0]       mode;
    logic             load;
    logic [N*W-1:0]   load_data;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     in_lo;
    logic [W-1:0]     in_hi;
    logic [N*W-1:0]   out_data;
    logic [W-1:0]     out_lo;
    logic [W-1:0]     out_hi;
    logic             busy;
    logic             done;

    modport master (
        output ena, mode, load, load_data, start, count, in_lo, in_hi,
        input  out_data, out_lo, out_hi, busy, done
    );

    modport slave (
        input  ena, mode, load, load_data, start, count, in_lo, in_hi,
        output out_data, out_lo, out_hi, busy, done
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal N x W shift register (shift/rotate up/down, parallel load) with an optional burst
// engine enabled by defining SHIFT_REG_UNIV_BURST_EN; without it start/count are ignored.
module shift_reg_univ #(
    parameter int unsigned W     = 1,
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 4
) (
    input logic             clk,
    input logic             rst,
    shift_reg_univ_if.slave bus
);
    logic [N*W-1:0] stage_q, stage_d;

    // Stage 0 sits in the least significant lane, so "up" moves lanes toward the MSBs.
    function automatic logic [N*W-1:0] shift_op(input logic [N*W-1:0] v,
                                                input logic [1:0]     m,
                                                input logic [W-1:0]   lo,
                                                input logic [W-1:0]   hi);
        logic [N*W-1:0] r;
        case (m)
            2'b00:   r = {v[(N-1)*W-1:0], lo};
            2'b01:   r = {hi, v[N*W-1:W]};
            2'b10:   r = {v[(N-1)*W-1:0], v[N*W-1 -: W]};
            default: r = {v[W-1:0], v[N*W-1:W]};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stage_q <= '0;
        else      stage_q <= stage_d;
    end

`ifdef SHIFT_REG_UNIV_BURST_EN
    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            StIdle: begin
                if (!bus.load && bus.start) begin
                    state_d = StBusy;
                    rem_d   = bus.count;
                    mode_d  = bus.mode;
                end
            end
            StBusy: begin
                // A load aborts the burst silently, even in the would-be done cycle.
                if (bus.load || rem_q == '0) state_d = StIdle;
                else if (bus.ena)            rem_d   = rem_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        if (bus.load) begin
            stage_d = bus.load_data;
        end else if (state_q == StBusy) begin
            if (rem_q != '0 && bus.ena)
                stage_d = shift_op(stage_q, mode_q, bus.in_lo, bus.in_hi);
        end else if (!bus.start && bus.ena) begin
            stage_d = shift_op(stage_q, bus.mode, bus.in_lo, bus.in_hi);
        end
        busy_d = (state_d == StBusy);
        done_d = (state_d == StBusy) && (rem_d == '0);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
`else
    always_comb begin
        stage_d = stage_q;
        if (bus.load)     stage_d = bus.load_data;
        else if (bus.ena) stage_d = shift_op(stage_q, bus.mode, bus.in_lo, bus.in_hi);
    end

    assign bus.busy = 1'b0;
    assign bus.done = 1'b0;
`endif

    assign bus.out_data = stage_q;
    assign bus.out_lo   = stage_q[W-1:0];
    assign bus.out_hi   = stage_q[N*W-1 -: W];
endmodule
